mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main control FSM for the RV32I core. It decodes the latched instruction's opcode and sequences the shared datapath (one ALU, one memory port, instruction register, PC) through fetch, decode, execute, memory and writeback steps. It drives `ALUop` into the ALU control decoder and handshakes with the unified memory port.

## Interface
Parameters: none.

- `clk` in 1: sole clock. Everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset. There is one clock, and reset is asynchronous active-low.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`, used for branch condition.
- `alu_zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: write request (sw).
- `adr_src` out 1: 0 = PC, 1 = ALUOut as memory address.
- `ir_write` out 1: load IR and oldPC.
- `pc_write` out 1: load PC from the result mux.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = const 4.
- `result_src` out 2: 00 = ALUOut, 01 = mem rdata, 10 = ALU result.
- `ALUop` out 2: 00 = add, 01 = branch compare, 10 = R-type, 11 = I-type.
- `instr_retire` out 1: one-cycle pulse when an instruction completes.
- `illegal_instr` out 1: sticky illegal-opcode flag. Exists only with the macro.

## Operation
- All outputs are Moore, decoded from `state_q`. The exceptions are the `mem_ready`-gated strobes and the branch `pc_write`.
- Unlisted outputs are 0 in every state.
- States and their actions:
  - BOOT: all outputs 0. Goes to FETCH.
  - FETCH: `mem_req`, `adr_src`=0, a=PC, b=4, `ALUop`=00, `result_src`=10. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE: a=oldPC, b=imm, `ALUop`=00 (branch/jal target into ALUOut). Dispatch on `opcode`:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111/0010111 → UPPER
    - other → ILLEGAL handling (see Configuration)
  - MEMADR: a=rs1, b=imm, `ALUop`=00. Goes to MEMREAD if `opcode[5]`=0, else MEMWRITE.
  - MEMREAD: `mem_req`, `adr_src`=1. Goes to MEMWB on `mem_ready`.
  - MEMWB: `result_src`=01, `reg_write`. Goes to FETCH.
  - MEMWRITE: `mem_req`, `mem_we`, `adr_src`=1. Goes to FETCH on `mem_ready`.
  - EXECR: a=rs1, b=rs2, `ALUop`=10. Goes to ALUWB.
  - EXECI: a=rs1, b=imm, `ALUop`=11. Goes to ALUWB.
  - ALUWB: `result_src`=00, `reg_write`. Goes to FETCH.
  - BRANCH: a=rs1, b=rs2, `ALUop`=01, `result_src`=00, `pc_write` = taken. Goes to FETCH.
  - JALR: a=rs1, b=imm, `ALUop`=00. Goes to JAL.
  - JAL: a=oldPC, b=4, `ALUop`=00, `result_src`=00, `pc_write`. Goes to ALUWB.
  - UPPER: a = `opcode[5]` ? zero : oldPC, b=imm, `ALUop`=00. Goes to ALUWB.
- Branch condition: taken = `alu_zero` ^ `funct3[0]` ^ `funct3[2]`. This covers beq, bne, blt, bge, bltu and bgeu. `funct3` 010/011 is treated as illegal.
- `instr_retire` is 1 on each transition into FETCH from MEMWB, MEMWRITE (with `mem_ready`), ALUWB, BRANCH, or from DECODE for an illegal opcode when the macro is absent.

## Timing
- Reset: `state_q`=BOOT. All outputs are 0 during reset and in the first cycle after release.
- CPI with zero wait states: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 4.
- Each wait cycle (`mem_ready`=0 in FETCH/MEMREAD/MEMWRITE) adds one cycle. While waiting, `mem_req`, `mem_we` and `adr_src` stay stable.
- `mem_ready` is ignored in all other states.
- Reset asserted mid-instruction returns to BOOT immediately. No partial `reg_write`/`pc_write` occurs after reset assertion.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode moves DECODE to TRAP.
  - TRAP: all strobes 0, `illegal_instr`=1. TRAP holds until reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode is a NOP: DECODE goes to FETCH with an `instr_retire` pulse.
  - There is no TRAP state and no `illegal_instr` port.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum
  - opcode constants
  - `ALUop` encodings
  - the `alu_src_a`/`alu_src_b`/`result_src` select encodings

  The datapath and the ALU control decoder share these.
- One sub-module: `branch_cond` (combinational; inputs `funct3` and `alu_zero`, output taken).

## Test plan
- Reset, then lw with `mem_ready` low for 2 cycles in FETCH and 1 in MEMREAD → 8 cycles. `reg_write` with `result_src`=01 in exactly one cycle; `instr_retire` pulses once.
- beq with `alu_zero`=1, then bne with `alu_zero`=1 → `pc_write`=1 in BRANCH for the first and 0 for the second; 3 cycles each.
- jalr (opcode 1100111) → state path FETCH, DECODE, JALR, JAL, ALUWB. `pc_write` in JAL, `reg_write` in ALUWB.
- Opcode 0000000 → with macro: TRAP, `illegal_instr`=1 persists for 10 cycles with no `mem_req`. Without macro: back in FETCH after 2 cycles.
- Reset asserted in MEMWRITE with `mem_ready`=0 → outputs 0 asynchronously; BOOT then FETCH after release.
- addi, then sub, then lui → `ALUop` 11, 10 and 00 respectively in the execute state; `alu_src_a`=11 for lui.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multi-cycle RV32I control path.
// State enum, opcode constants, ALUop and mux-select encodings, shared by the
// main control FSM, the datapath and the ALU control decoder.
// Build option: CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_UPPER
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } ctrl_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Branch funct3 010/011 have no RV32I meaning and are rejected with the
    // unknown opcodes.
    function automatic logic op_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            OP_BRANCH:                         return f3[2:1] != 2'b01;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: unified memory port handshake between control FSM and memory.
interface mc_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/branch_cond.sv
// branch_cond: branch-taken decision from funct3 and the ALU zero flag.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    output logic       taken
);
    // funct3[0] inverts eq/ge sense, funct3[2] flips for the slt-based compares;
    // the 01x encodings never reach BRANCH but are forced not-taken anyway.
    assign taken = (alu_zero ^ funct3[0] ^ funct3[2]) & (funct3[2] | ~funct3[1]);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle main control FSM for the RV32I core.
// Build option: CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap instead of NOP).
//
// state    | meaning
// ---------+------------------------------------------------
// BOOT     | first cycle after reset, all outputs 0
// FETCH    | read instr at PC, PC+4 into PC, load IR/oldPC
// DECODE   | oldPC+imm into ALUOut, dispatch on opcode
// MEMADR   | rs1+imm address for lw/sw
// MEMREAD  | load request at ALUOut
// MEMWB    | write load data to rd
// MEMWRITE | store request at ALUOut
// EXECR    | R-type ALU op
// EXECI    | I-type ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, PC <- target if taken
// JALR     | rs1+imm into ALUOut
// JAL      | PC <- ALUOut, oldPC+4 into ALUOut
// UPPER    | lui/auipc: imm + (zero | oldPC)
// TRAP     | illegal opcode, hold until reset (macro only)
module mc_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    alu_zero,
    mc_control_fsm_if.master        mem,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    reg_write,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              result_src,
    output logic [1:0]              ALUop,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                    illegal_instr,
`endif
    output logic                    instr_retire
);

    ctrl_state_e state_q;
    logic        taken;
    logic        legal;

    branch_cond u_branch_cond (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .taken    (taken)
    );

    assign legal = op_legal(opcode, funct3);

    // State register and next-state sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            case (state_q)
                S_BOOT:     state_q <= S_FETCH;
                S_FETCH:    if (mem.mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_q <= S_TRAP;
`else
                        state_q <= S_FETCH;
`endif
                    end else begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state_q <= S_MEMADR;
                            OP_RTYPE:          state_q <= S_EXECR;
                            OP_ITYPE:          state_q <= S_EXECI;
                            OP_BRANCH:         state_q <= S_BRANCH;
                            OP_JAL:            state_q <= S_JAL;
                            OP_JALR:           state_q <= S_JALR;
                            default:           state_q <= S_UPPER;
                        endcase
                    end
                end
                S_MEMADR:   state_q <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem.mem_ready) state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: if (mem.mem_ready) state_q <= S_FETCH;
                S_EXECR:    state_q <= S_ALUWB;
                S_EXECI:    state_q <= S_ALUWB;
                S_ALUWB:    state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                S_JALR:     state_q <= S_JAL;
                S_JAL:      state_q <= S_ALUWB;
                S_UPPER:    state_q <= S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP:     state_q <= S_TRAP;
`endif
                default:    state_q <= S_BOOT;
            endcase
        end
    end

    // Moore decode of state_q; only mem_ready strobes and branch pc_write look at inputs.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.adr_src  = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        result_src   = RES_ALUOUT;
        ALUop        = ALUOP_ADD;
        instr_retire = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALU;
                ir_write    = mem.mem_ready;
                pc_write    = mem.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
`ifndef CTRL_ILLEGAL_TRAP_EN
                instr_retire = ~legal;
`endif
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src   = RES_RDATA;
                reg_write    = 1'b1;
                instr_retire = 1'b1;
            end
            S_MEMWRITE: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b1;
                mem.adr_src  = 1'b1;
                instr_retire = mem.mem_ready;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                ALUop     = ALUOP_RTYPE;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                ALUop     = ALUOP_ITYPE;
            end
            S_ALUWB: begin
                result_src   = RES_ALUOUT;
                reg_write    = 1'b1;
                instr_retire = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                ALUop        = ALUOP_BRANCH;
                result_src   = RES_ALUOUT;
                pc_write     = taken;
                instr_retire = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
            end
            S_UPPER: begin
                // lui has opcode[5]=1 and adds imm to zero; auipc adds to oldPC.
                alu_src_a = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized bench for mc_control_fsm with an instruction-level
// reference model. Honors CTRL_ILLEGAL_TRAP_EN like the design.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       alu_zero = 1'b0;
    logic       ir_write, pc_write, reg_write, instr_retire;
    logic [1:0] alu_src_a, alu_src_b, result_src, ALUop;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_instr;
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mc_control_fsm_if mem_bus ();

    mc_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .alu_zero      (alu_zero),
        .mem           (mem_bus),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .ALUop         (ALUop),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .instr_retire  (instr_retire)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word: {req, we, adr, irw, pcw, rw, a, b, res, aluop, retire}.
    function automatic logic [14:0] cw(input bit req, input bit we, input bit adr,
                                       input bit irw, input bit pcw, input bit rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [1:0] aop,
                                       input bit ret);
        return {req, we, adr, irw, pcw, rw, a, b, res, aop, ret};
    endfunction

    function automatic logic [14:0] act_word();
        return {mem_bus.mem_req, mem_bus.mem_we, mem_bus.adr_src, ir_write, pc_write,
                reg_write, alu_src_a, alu_src_b, result_src, ALUop, instr_retire};
    endfunction

    function automatic bit act_ill();
`ifdef CTRL_ILLEGAL_TRAP_EN
        return illegal_instr;
`else
        return 1'b0;
`endif
    endfunction

    // 0 illegal, 1 lw, 2 sw, 3 R, 4 I, 5 branch, 6 jal, 7 jalr, 8 lui/auipc
    function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b0110011: return 3;
            7'b0010011: return 4;
            7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? 0 : 5;
            7'b1101111: return 6;
            7'b1100111: return 7;
            7'b0110111, 7'b0010111: return 8;
            default: return 0;
        endcase
    endfunction

    // Branch semantics: the ALU subtracts for eq/ne and computes slt/sltu otherwise.
    function automatic bit br_taken(input logic [2:0] f3, input bit zero);
        case (f3)
            3'b000:  return zero;    // beq
            3'b001:  return !zero;   // bne
            3'b100:  return !zero;   // blt: slt result 1
            3'b101:  return zero;    // bge
            3'b110:  return !zero;   // bltu
            default: return zero;    // bgeu
        endcase
    endfunction

    typedef struct {
        logic [14:0] w;
        int          kind;   // 0 free inputs, 1 memory handshake, 2 branch compare
        bit          rdy;
        bit          fetch;
        bit          ill;
    } step_t;

    step_t q[$];

    task automatic push(input logic [14:0] w, input int kind, input bit rdy,
                        input bit fetch, input bit ill);
        step_t s;
        s.w = w; s.kind = kind; s.rdy = rdy; s.fetch = fetch; s.ill = ill;
        q.push_back(s);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_val({tag, "_rst_outs"}, 32'(act_word()), 32'd0);
        check_val({tag, "_rst_ill"}, 32'(act_ill()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mem_bus.mem_ready = 1'($urandom);
        opcode = 7'($urandom);
        #2;
        check_val({tag, "_boot"}, 32'(act_word()), 32'd0);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit zero,
                             input int fw, input int mw, input string tag, input int stop_at);
        int cls;
        int rt;
        logic [14:0] aluwb;
        logic [14:0] memadr;
        q.delete();
        cls = classify(op, f3);
        aluwb  = cw(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1);
        memadr = cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
        for (int i = 0; i < fw; i++)
            push(cw(1,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0), 1, 0, 1, 0);
        push(cw(1,0,0,1,1,0,2'b00,2'b10,2'b10,2'b00,0), 1, 1, 1, 0);
        push(cw(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00, (cls == 0) && !TRAP_EN), 0, 0, 0, 0);
        case (cls)
            0: if (TRAP_EN) for (int i = 0; i < 10; i++) push(15'd0, 0, 0, 0, 1);
            1: begin
                push(memadr, 0, 0, 0, 0);
                for (int i = 0; i < mw; i++)
                    push(cw(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), 1, 0, 0, 0);
                push(cw(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), 1, 1, 0, 0);
                push(cw(0,0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,1), 0, 0, 0, 0);
            end
            2: begin
                push(memadr, 0, 0, 0, 0);
                for (int i = 0; i < mw; i++)
                    push(cw(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), 1, 0, 0, 0);
                push(cw(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,1), 1, 1, 0, 0);
            end
            3: begin
                push(cw(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0), 0, 0, 0, 0);
                push(aluwb, 0, 0, 0, 0);
            end
            4: begin
                push(cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b11,0), 0, 0, 0, 0);
                push(aluwb, 0, 0, 0, 0);
            end
            5: push(cw(0,0,0,0,br_taken(f3, zero),0,2'b10,2'b00,2'b00,2'b01,1), 2, 0, 0, 0);
            6: begin
                push(cw(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0), 0, 0, 0, 0);
                push(aluwb, 0, 0, 0, 0);
            end
            7: begin
                push(cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0), 0, 0, 0, 0);
                push(cw(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0), 0, 0, 0, 0);
                push(aluwb, 0, 0, 0, 0);
            end
            default: begin
                push(cw(0,0,0,0,0,0, (op == 7'b0110111) ? 2'b11 : 2'b01, 2'b01,2'b00,2'b00,0),
                     0, 0, 0, 0);
                push(aluwb, 0, 0, 0, 0);
            end
        endcase
        rt = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == stop_at) return;
            @(negedge clk);
            opcode   = q[i].fetch ? 7'($urandom) : op;
            funct3   = q[i].fetch ? 3'($urandom) : f3;
            alu_zero = (q[i].kind == 2) ? zero : 1'($urandom);
            mem_bus.mem_ready = (q[i].kind == 1) ? q[i].rdy : 1'($urandom);
            #2;
            check_val($sformatf("%s[%0d]", tag, i), 32'(act_word()), 32'(q[i].w));
            if (TRAP_EN)
                check_val($sformatf("%s_ill[%0d]", tag, i), 32'(act_ill()), 32'(q[i].ill));
            rt += int'(instr_retire);
        end
        check_val({tag, "_retire"}, 32'(rt), ((cls == 0) && TRAP_EN) ? 32'd0 : 32'd1);
        if (cls == 0 && TRAP_EN) do_reset({tag, "_trap"});
    endtask

    localparam logic [6:0] OPS [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                       7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                       7'b0010111};

    initial begin
        mem_bus.mem_ready = 1'b0;
        #3;
        do_reset("init");
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 1, "lw_wait", -1);
        run_instr(7'b1100011, 3'b000, 1'b1, 0, 0, "beq", -1);
        run_instr(7'b1100011, 3'b001, 1'b1, 0, 0, "bne", -1);
        run_instr(7'b1100111, 3'b000, 1'b0, 0, 0, "jalr", -1);
        run_instr(7'b0010011, 3'b000, 1'b0, 0, 0, "addi", -1);
        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, "sub", -1);
        run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, "lui", -1);
        run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, "illegal", -1);
        run_instr(7'b1100011, 3'b011, 1'b0, 1, 0, "br_f3_bad", -1);
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 3, "sw_rst", 4);
        do_reset("sw_rst");
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 8)];
            run_instr(op, 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 2), $sformatf("rnd%0d", n), -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
